// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared text-overlay constants, message IDs and controller state type
//
// Purpose: constants and helpers shared by the text buffer controller and its
// message ROM.
// Contents:
//   TXT_COLS / TXT_ROWS  character grid size (32 x 8)
//   CHAR_SPACE           ASCII space, used as the clear/fill code
//   MSG_*                message IDs understood by text_msg_rom
//   txt_ctrl_state_t     controller FSM states
//   msg_char()           character at (msg, col) of the built-in message table
package draw_pkg;

  localparam int TXT_COLS = 32;
  localparam int TXT_ROWS = 8;
  localparam logic [6:0] CHAR_SPACE = 7'h20;

  localparam logic [4:0] MSG_START = 5'd0;
  localparam logic [4:0] MSG_SCORE = 5'd1;
  localparam logic [4:0] MSG_MISS  = 5'd2;
  localparam logic [4:0] MSG_GOAL  = 5'd3;

  typedef enum logic [1:0] {
    TXT_IDLE,
    TXT_CLEAR,
    TXT_COPY,
    TXT_DONE
  } txt_ctrl_state_t;

  // Messages are stored as 16-char left-aligned strings; columns 16..31 and
  // unused message IDs are spaces.
  function automatic logic [6:0] msg_char(input logic [4:0] msg, input logic [4:0] col);
    logic [127:0] text;
    logic [3:0]   idx;
    logic [6:0]   ch;
    case (msg)
      MSG_START: text = "PRESS START     ";
      MSG_SCORE: text = "SCORE           ";
      MSG_MISS:  text = "MISS            ";
      MSG_GOAL:  text = "GOAL!           ";
      default:   text = {16{8'h20}};
    endcase
    // Leftmost character sits in the most significant byte of the literal.
    idx = 4'd15 - col[3:0];
    if (col[4]) ch = CHAR_SPACE;
    else        ch = text[{idx, 3'b000} +: 7];
    return ch;
  endfunction

endpackage

// File: rtl/text_msg_rom.sv
// rtl/text_msg_rom.sv - synchronous message ROM, 32 messages x 32 chars
//
// Purpose: returns one 7-bit ASCII character per cycle, one cycle after addr.
// Ports:
//   clk   in   clock
//   addr  in   {msg[4:0], col[4:0]}
//   data  out  registered character
module text_msg_rom
  import draw_pkg::*;
(
  input  logic       clk,
  input  logic [9:0] addr,
  output logic [6:0] data
);

  always_ff @(posedge clk) begin
    data <= msg_char(addr[9:5], addr[4:0]);
  end

endmodule

// File: rtl/text_buffer_ctrl.sv
// rtl/text_buffer_ctrl.sv - 32x8 character buffer with clear and round-robin message copy
//
// Purpose: owns the text overlay character RAM; clears it on reset or clr_req
// and copies 32-char messages from text_msg_rom into rows on behalf of two
// requesters arbitrated round-robin.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   a_valid/a_row/a_msg/a_ready    requester A (game FSM)
//   b_valid/b_row/b_msg/b_ready    requester B (score updater)
//   clr_req                        level request to clear the buffer
//   rd_xy / rd_char                renderer read port {row[3:0], col[7:0]} -> char (1-cycle)
//   busy / done                    operation in progress / one-cycle completion pulse
module text_buffer_ctrl
  import draw_pkg::*;
#(
  parameter int         COLS     = TXT_COLS,
  parameter int         ROWS     = TXT_ROWS,
  parameter logic [6:0] CLR_CHAR = CHAR_SPACE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [2:0]  a_row,
  input  logic [4:0]  a_msg,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [2:0]  b_row,
  input  logic [4:0]  b_msg,
  output logic        b_ready,
  input  logic        clr_req,
  input  logic [11:0] rd_xy,
  output logic [6:0]  rd_char,
  output logic        busy,
  output logic        done
);

  txt_ctrl_state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [2:0] row_q;
  logic [4:0] msg_q;
  logic       cur_b;   // requester being served is B
  logic       last_b;  // last completed copy was for B
  logic       win_b;
  logic       accept;

  logic [9:0] rom_addr;
  logic [6:0] rom_data;
  logic       we;
  logic [7:0] waddr;
  logic [6:0] wdata;
  logic [6:0] mem [256];

  logic [3:0] rd_row;
  logic [7:0] rd_col;
  logic       rd_in_range;

  // With no valid requester the winner is whoever was not served last, so
  // exactly one ready is offered while idle.
  always_comb begin
    if (a_valid) win_b = b_valid && !last_b;
    else         win_b = b_valid || !last_b;
  end

  assign rom_addr = {msg_q, cnt[4:0]};

  text_msg_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    we       = 1'b0;
    waddr    = cnt;
    wdata    = CLR_CHAR;
    case (state)
      TXT_IDLE: begin
        if (clr_req) begin
          state_nx = TXT_CLEAR;
          cnt_nx   = 8'd0;
        end else begin
          a_ready = !win_b;
          b_ready = win_b;
          if ((a_valid && !win_b) || (b_valid && win_b)) begin
            accept   = 1'b1;
            state_nx = TXT_COPY;
            cnt_nx   = 8'd0;
          end
        end
      end
      TXT_CLEAR: begin
        busy   = 1'b1;
        we     = 1'b1;
        cnt_nx = cnt + 8'd1;
        if (cnt == 8'd255) state_nx = TXT_DONE;
      end
      TXT_COPY: begin
        // ROM data lags its address by one cycle, so cycle k writes column k-1.
        busy   = 1'b1;
        we     = (cnt != 8'd0);
        waddr  = {row_q, cnt[4:0] - 5'd1};
        wdata  = rom_data;
        cnt_nx = cnt + 8'd1;
        if (cnt == 8'd32) state_nx = TXT_DONE;
      end
      TXT_DONE: begin
        done     = 1'b1;
        state_nx = TXT_IDLE;
      end
      default: state_nx = TXT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= TXT_CLEAR;
      cnt    <= 8'd0;
      row_q  <= 3'd0;
      msg_q  <= 5'd0;
      cur_b  <= 1'b0;
      last_b <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        row_q <= win_b ? b_row : a_row;
        msg_q <= win_b ? b_msg : a_msg;
        cur_b <= win_b;
      end
      // Only a copy that runs to completion moves the round-robin pointer.
      if (state == TXT_COPY && cnt == 8'd32) last_b <= cur_b;
    end
  end

  // Reset aborts any write in flight; the post-reset clear rewrites everything.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= wdata;
  end

  assign rd_row      = rd_xy[11:8];
  assign rd_col      = rd_xy[7:0];
  assign rd_in_range = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);

  // Read-first: a same-cycle write to this cell is seen on the following read.
  always_ff @(posedge clk) begin
    if (rst)              rd_char <= CLR_CHAR;
    else if (rd_in_range) rd_char <= mem[{rd_row[2:0], rd_col[4:0]}];
    else                  rd_char <= CLR_CHAR;
  end

endmodule
